// File: rtl/repeat_range.sv
// repeat_range: emits every element of the signed range range(base, limit, step)
// exactly `reps` times as the tuple (element, repeat index). It uses the
// _start / _ready / _valid / _done generator handshake, so a parent generator
// can drive it as a sub-generator. One tuple is produced per cycle while the
// consumer keeps _ready high.
module repeat_range #(
  parameter int WIDTH     = 32,
  parameter int REP_WIDTH = 8
) (
  input  logic                        _clock,
  input  logic                        _reset,
  input  logic                        _start,
  input  logic signed [WIDTH-1:0]     base,
  input  logic signed [WIDTH-1:0]     limit,
  input  logic signed [WIDTH-1:0]     step,
  input  logic        [REP_WIDTH-1:0] reps,
  input  logic                        _ready,
  output logic                        _valid,
  output logic                        _done,
  output logic signed [WIDTH-1:0]     _0,
  output logic        [REP_WIDTH-1:0] _1
);

  typedef enum logic {
    ST_DONE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic signed [WIDTH-1:0]     limit_q, limit_d;
  logic signed [WIDTH-1:0]     step_q,  step_d;
  logic        [REP_WIDTH-1:0] reps_q,  reps_d;
  logic signed [WIDTH-1:0]     cur_q,   cur_d;
  logic        [REP_WIDTH-1:0] rep_q,   rep_d;

  // Candidates are carried one bit wider than the data path, so that the sum of
  // the current element and the step can never wrap around.
  logic signed [WIDTH:0]       base_wide;
  logic signed [WIDTH:0]       next_elem;
  logic        [REP_WIDTH:0]   rep_inc;
  logic                        base_ok;
  logic                        next_ok;
  logic                        more_reps;

  // Range membership at WIDTH+1 bits. A value that does not fit back into the
  // WIDTH-bit signed range is outside the range, and a zero step gives an empty
  // range.
  function automatic logic in_range(
    input logic signed [WIDTH:0]   x,
    input logic signed [WIDTH-1:0] lim,
    input logic signed [WIDTH-1:0] stp
  );
    logic signed [WIDTH:0] lim_wide;
    logic                  fits;
    lim_wide = {lim[WIDTH-1], lim};
    fits     = (x[WIDTH] == x[WIDTH-1]);
    if (stp > 0) begin
      return fits && (x < lim_wide);
    end else if (stp < 0) begin
      return fits && (x > lim_wide);
    end else begin
      return 1'b0;
    end
  endfunction

  // Arithmetic that feeds the next-state decision.
  always_comb begin
    base_wide = {base[WIDTH-1], base};
    next_elem = {cur_q[WIDTH-1], cur_q} + {step_q[WIDTH-1], step_q};
    rep_inc   = {1'b0, rep_q} + (REP_WIDTH+1)'(1);
    more_reps = (rep_inc < {1'b0, reps_q});
    base_ok   = (reps != '0) && in_range(base_wide, limit, step);
    next_ok   = in_range(next_elem, limit_q, step_q);
  end

  // Next-state and next-output logic. _start has priority over any pending
  // transfer, and _ready only matters while a tuple is being offered.
  always_comb begin
    // NOTE: every signal gets a default first, so that no path through this
    // block leaves a value unassigned and infers a latch.
    state_d = state_q;
    limit_d = limit_q;
    step_d  = step_q;
    reps_d  = reps_q;
    cur_d   = cur_q;
    rep_d   = rep_q;

    if (_start) begin
      limit_d = limit;
      step_d  = step;
      reps_d  = reps;
      if (base_ok) begin
        state_d = ST_EMIT;
        cur_d   = base;
        rep_d   = '0;
      end else begin
        state_d = ST_DONE;
      end
    end else if (state_q == ST_EMIT && _ready) begin
      if (more_reps) begin
        rep_d = rep_inc[REP_WIDTH-1:0];
      end else if (next_ok) begin
        cur_d = next_elem[WIDTH-1:0];
        rep_d = '0;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  // State and captured-parameter registers, cleared asynchronously.
  always_ff @(posedge _clock or posedge _reset) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers
    // update together on the edge regardless of statement order.
    if (_reset) begin
      state_q <= ST_DONE;
      limit_q <= '0;
      step_q  <= '0;
      reps_q  <= '0;
      cur_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      step_q  <= step_d;
      reps_q  <= reps_d;
      cur_q   <= cur_d;
      rep_q   <= rep_d;
    end
  end

  // The outputs come straight from registers. The one-bit state register is
  // itself the valid flag, so no input reaches an output without passing
  // through a flop.
  assign _valid = (state_q == ST_EMIT);
  assign _done  = (state_q == ST_DONE);
  assign _0     = cur_q;
  assign _1     = rep_q;

endmodule

// File: tb/tb_repeat_range.sv
// Self-checking bench for repeat_range. It runs a table of directed vectors,
// hand-written restart and reset sequences, and randomized ranges. The bench
// compares every cycle against a queue model of range() with repeats.
module tb_repeat_range;

  localparam int W  = 8;
  localparam int RW = 4;
  localparam int EMIN = -(1 << (W-1));
  localparam int EMAX = (1 << (W-1)) - 1;

  logic                 _clock = 1'b0;
  logic                 _reset;
  logic                 _start;
  logic                 _ready;
  logic signed [W-1:0]  base, limit, step;
  logic        [RW-1:0] reps;
  logic                 _valid, _done;
  logic signed [W-1:0]  _0;
  logic        [RW-1:0] _1;

  repeat_range #(.WIDTH(W), .REP_WIDTH(RW)) dut (
    ._clock(_clock), ._reset(_reset), ._start(_start),
    .base(base), .limit(limit), .step(step), .reps(reps),
    ._ready(_ready), ._valid(_valid), ._done(_done), ._0(_0), ._1(_1)
  );

  always #5 _clock = ~_clock;

  int total = 0;
  int bad   = 0;

  int exp_e[$];
  int exp_r[$];

  typedef struct {
    int b; int l; int s; int r;
    int mode;      // 0: ready high, 1: ready toggles 1,0,..., 2: random ready
    int exp_n;     // number of transfers
    int exp_last;  // element of the last transfer
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: Python-style range() with the stated step-0 and overflow
  // rules, with each element repeated r times.
  task automatic model_fill(input int b, input int l, input int s, input int r);
    exp_e.delete();
    exp_r.delete();
    if (s == 0 || r == 0) return;
    for (int x = b; ((s > 0) ? (x < l) : (x > l)) && x >= EMIN && x <= EMAX; x += s)
      for (int k = 0; k < r; k++) begin
        exp_e.push_back(x);
        exp_r.push_back(k);
      end
  endtask

  // Called just after a falling edge. It issues _start on the next rising edge
  // and checks every cycle until the model queue drains.
  task automatic run_case(input int b, input int l, input int s, input int r,
                          input int mode, output int n, output int last);
    int   cyc;
    int   budget;
    int   e0, r0;
    logic rdy;
    model_fill(b, l, s, r);
    base   = b[W-1:0];
    limit  = l[W-1:0];
    step   = s[W-1:0];
    reps   = r[RW-1:0];
    _start = 1'b1;
    @(negedge _clock);
    _start = 1'b0;
    n = 0;
    last = 0;
    cyc = 0;
    budget = 4 * exp_e.size() + 20;
    if (exp_e.size() == 0) begin
      repeat (3) begin
        check("empty_idle", {30'd0, _valid, _done}, 32'b01);
        @(negedge _clock);
      end
    end else begin
      while (exp_e.size() > 0) begin
        if (cyc > budget) begin
          check("cycle_budget", exp_e.size(), 0);
          break;
        end
        e0 = exp_e[0];
        r0 = exp_r[0];
        check("tuple", {18'd0, _valid, _done, _0, _1},
              {18'd0, 2'b10, e0[W-1:0], r0[RW-1:0]});
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2 == 0);
          default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        _ready = rdy;
        if (rdy) begin
          if (_valid) begin
            n++;
            last = int'(_0);
          end
          void'(exp_e.pop_front());
          void'(exp_r.pop_front());
        end
        @(negedge _clock);
        cyc++;
      end
    end
    check("finished", {30'd0, _valid, _done}, 32'b01);
  endtask

  initial begin
    int n, last;

    vecs[0]  = '{0,    10,   2,    2,  0, 10, 8};
    vecs[1]  = '{5,    -1,   -3,   3,  1, 6,  2};
    vecs[2]  = '{0,    10,   2,    0,  0, 0,  0};
    vecs[3]  = '{3,    10,   0,    2,  0, 0,  0};
    vecs[4]  = '{10,   10,   1,    1,  0, 0,  0};
    vecs[5]  = '{120,  127,  5,    1,  0, 2,  125};
    vecs[6]  = '{-120, -128, -5,   1,  1, 2,  -125};
    vecs[7]  = '{-128, 127,  127,  1,  0, 3,  126};
    vecs[8]  = '{127,  -128, -128, 2,  2, 4,  -1};
    vecs[9]  = '{0,    5,    1,    15, 2, 75, 4};
    vecs[10] = '{5,    10,   -1,   1,  0, 0,  0};

    _reset = 1'b1;
    _start = 1'b0;
    _ready = 1'b0;
    base = '0; limit = '0; step = '0; reps = '0;
    #1;
    check("reset_state", {18'd0, _valid, _done, _0, _1}, {18'd0, 2'b01, 8'd0, 4'd0});
    repeat (2) @(negedge _clock);
    _reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      run_case(vecs[i].b, vecs[i].l, vecs[i].s, vecs[i].r, vecs[i].mode, n, last);
      check($sformatf("vec%0d_count", i), n, vecs[i].exp_n);
      if (vecs[i].exp_n > 0) check($sformatf("vec%0d_last", i), last, vecs[i].exp_last);
    end

    // Restart while a tuple is pending and _ready is high on the restart edge.
    base = 8'sd0; limit = 8'sd100; step = 8'sd1; reps = 4'd2;
    _start = 1'b1;
    @(negedge _clock);
    _start = 1'b0;
    _ready = 1'b1;
    check("restart_t0", {18'd0, _valid, _done, _0, _1}, {18'd0, 2'b10, 8'd0, 4'd0});
    @(negedge _clock);
    check("restart_t1", {18'd0, _valid, _done, _0, _1}, {18'd0, 2'b10, 8'd0, 4'd1});
    @(negedge _clock);
    check("restart_t2", {18'd0, _valid, _done, _0, _1}, {18'd0, 2'b10, 8'd1, 4'd0});
    @(negedge _clock);
    run_case(50, 52, 1, 1, 0, n, last);
    check("restart_count", n, 2);
    check("restart_last", last, 51);

    // Asynchronous reset between edges while a tuple is offered.
    base = 8'sd0; limit = 8'sd10; step = 8'sd1; reps = 4'd3;
    _start = 1'b1;
    @(negedge _clock);
    _start = 1'b0;
    _ready = 1'b1;
    @(negedge _clock);
    check("pre_reset", {18'd0, _valid, _done, _0, _1}, {18'd0, 2'b10, 8'd0, 4'd1});
    #2 _reset = 1'b1;
    #1;
    check("async_reset", {18'd0, _valid, _done, _0, _1}, {18'd0, 2'b01, 8'd0, 4'd0});
    @(negedge _clock);
    _reset = 1'b0;
    run_case(-3, 2, 2, 2, 1, n, last);
    check("post_reset_count", n, 6);
    check("post_reset_last", last, 1);

    // Randomized ranges with random backpressure against the model.
    for (int i = 0; i < 30; i++) begin
      int b, l, s, r;
      b = int'($urandom_range(0, 255)) - 128;
      l = int'($urandom_range(0, 255)) - 128;
      s = int'($urandom_range(0, 16)) - 8;
      r = int'($urandom_range(0, 3));
      run_case(b, l, s, r, 2, n, last);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/repeat_range.md
# repeat_range

Parametrised generator block that emits every element of a signed integer range `range(base, limit, step)` exactly `reps` times, with the element and its repeat index as the output tuple. It generalises the fixed duplicate-range generator. It adds configurable data width, a run-time repeat count, and negative-step support. The range counter is held internally, so it can emit one element per cycle. It sits beside the other generator modules and follows the same `_start` / `_ready` / `_valid` / `_done` protocol, so a parent generator can instantiate it as a sub-generator.

## Interface
Parameters:
- `WIDTH`, 32, width of `base`, `limit`, `step` and `_0` (signed)
- `REP_WIDTH`, 8, width of `reps` and `_1` (unsigned)

Ports:
- `_clock`  in  1  single clock; all state changes on its rising edge
- `_reset`  in  1  asynchronous, active-high reset
- `_start`  in  1  capture inputs on this edge and begin generating
- `base`  in  WIDTH  first range value (signed)
- `limit`  in  WIDTH  exclusive range bound (signed)
- `step`  in  WIDTH  range increment (signed, may be negative)
- `reps`  in  REP_WIDTH  times each element is emitted (unsigned)
- `_ready`  in  1  consumer can accept output this cycle
- `_valid`  out  1  `_0`/`_1` hold a valid tuple
- `_done`  out  1  generator exhausted / idle
- `_0`  out  WIDTH  current range element (signed)
- `_1`  out  REP_WIDTH  repeat index of the current element, 0..reps-1

## Operation
- Internal registers:
  - captured `limit`, `step` and `reps`;
  - `cur`, the current element;
  - `rep`, the repeat index;
  - state, either DONE or EMIT.
- Range membership:
  - for `step > 0`, x is in range when x < limit;
  - for `step < 0`, x is in range when x > limit;
  - `step == 0` gives an empty range. This is a defined behaviour; Python's error is not modelled.
- Next-element arithmetic:
  - `cur + step` is computed at WIDTH+1 bits and compared at WIDTH+1 bits;
  - a result outside the WIDTH-bit signed range is out of range and terminates generation, with no wrap-around.
- DONE state: `_valid=0`, `_done=1`.
- `_start` in any state:
  - captures the inputs, regardless of `_ready` or a pending output;
  - if `reps==0`, or `step==0`, or `base` is not in range, the block goes to DONE and `_done` stays 1 with no low pulse;
  - otherwise it goes to EMIT with `_0<=base`, `_1<=0`, `_valid<=1`, `_done<=0`.
- `_start` during EMIT abandons the current sequence; the pending tuple is discarded even if `_ready` is high on that edge.
- EMIT state, on an edge with `_valid && _ready` (a transfer), the first matching case applies:
  - if `rep+1 < reps`: `_1<=rep+1`, `_0` unchanged;
  - else if `cur+step` is in range: `_0<=cur+step`, `_1<=0`;
  - otherwise: `_valid<=0`, `_done<=1`, go to DONE.
- EMIT state, when `_ready` is low, all outputs hold stable.
- Inputs `base`, `limit`, `step` and `reps` are sampled only on `_start` edges; changes at other times are ignored.
- `_ready` has no effect while `_valid=0`.

## Timing
- Reset values, applied asynchronously: state DONE, `_valid=0`, `_done=1`, `_0=0`, `_1=0`, and all internal registers 0.
- Reset overrides `_start`. A reset asserted during EMIT drops the pending tuple immediately.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Start latency: after a `_start` edge at cycle k, the first tuple is valid in cycle k+1.
- Throughput: with `_ready` held high, one tuple transfers per cycle.
  - A sequence of n elements completes in n·reps transfers on consecutive edges.
  - `_done` rises in the cycle after the last transfer.
- Backpressure:
  - `_valid` never drops without a transfer, except on `_start` or `_reset`;
  - `_0` and `_1` never change while `_valid && !_ready`.

## Test plan
- Basic repeat, reproducing the original duplicate generator:
  - stimulus: `base=0`, `limit=10`, `step=2`, `reps=2`, `_ready` held high;
  - response: (0,0)(0,1)(2,0)(2,1)(4,0)(4,1)(6,0)(6,1)(8,0)(8,1) on 10 consecutive cycles starting one cycle after `_start`, then `_done=1`.
- Negative step with backpressure:
  - stimulus: `base=5`, `limit=-1`, `step=-3`, `reps=3`, `_ready` toggling 1,0,1,0;
  - response: (5,0)(5,1)(5,2)(2,0)(2,1)(2,2), each tuple held unchanged across the `_ready=0` cycles, then `_done`.
- Empty cases:
  - each of `reps=0`; `step=0`; and `base=10, limit=10, step=1` never raises `_valid`, and `_done` stays 1 throughout.
- Overflow boundary:
  - stimulus: WIDTH=8, `base=120`, `limit=127`, `step=5`, `reps=1`;
  - response: (120,0)(125,0), then `_done`, with no wrap to a negative value.
- Restart mid-sequence:
  - stimulus: `_start` with `0,100,1,2`; after 3 transfers, `_start` again with `50,52,1,1` while `_valid` is high;
  - response: the next tuples are exactly (50,0)(51,0), then `_done`.
- Asynchronous reset during EMIT:
  - stimulus: assert `_reset` between clock edges;
  - response: `_valid=0` and `_done=1` immediately, without waiting for a clock edge; a subsequent `_start` runs normally.
